// File: rtl/pll_pkg.sv
// Shared PLL definitions: data widths, midscale/Nyquist constants and the DCO tuning-word mapping.
package pll_pkg;

  localparam int unsigned DAC_W = 20;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned DIV_W = 8;

  localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] FCW_MAX = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic [ACC_W-1:0] fcw;
    logic             sat;
  } fcw_sat_t;

  // Offset-binary tuning word -> clamped FCW; two guard bits keep the sum from overflowing.
  function automatic fcw_sat_t calc_fcw(logic [DAC_W-1:0] dac, logic [ACC_W-1:0] center,
                                        int unsigned shift);
    logic signed [DAC_W-1:0] tune;
    logic signed [ACC_W+1:0] tune_x;
    logic signed [ACC_W+1:0] raw;
    fcw_sat_t                res;
    tune   = signed'(dac ^ DAC_MID);
    tune_x = tune;
    raw    = signed'({2'b00, center}) + (tune_x <<< shift);
    if (raw[ACC_W+1]) begin
      res = '{fcw: '0, sat: 1'b1};
    end else if (raw > signed'({2'b00, FCW_MAX})) begin
      res = '{fcw: FCW_MAX, sat: 1'b1};
    end else begin
      res = '{fcw: raw[ACC_W-1:0], sat: 1'b0};
    end
    return res;
  endfunction

endpackage

// File: rtl/dco_nco_if.sv
// DCO tuning/output bundle; master drives the tuning word and divide ratio, slave is the DCO.
interface dco_nco_if;
  import pll_pkg::*;

  logic [DAC_W-1:0] dac;
  logic [DIV_W-1:0] div_ratio;
  logic             dco_out;
  logic             fb_clk;
  logic [ACC_W-1:0] phase;
  logic [ACC_W-1:0] fcw;
  logic             sat;

  modport master (output dac, div_ratio, input dco_out, fb_clk, phase, fcw, sat);
  modport slave  (input dac, div_ratio, output dco_out, fb_clk, phase, fcw, sat);
endinterface

// File: rtl/fb_divider.sv
// Feedback divider: toggles fb_clk_o every N rising edges of dco_i; N re-sampled at each reload.
module fb_divider
  import pll_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             dco_i,
  input  logic [DIV_W-1:0] div_ratio_i,
  output logic             fb_clk_o
);

  logic             dco_prev_q;
  logic             fb_q, fb_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] ratio_q, ratio_d;
  logic [DIV_W-1:0] ratio_use;
  logic [DIV_W-1:0] n_eff;
  logic             rise;

  assign rise = dco_i & ~dco_prev_q;
  // Between reload and the first edge of a half-period the live ratio is used; it is then held.
  assign ratio_use = (cnt_q == '0) ? div_ratio_i : ratio_q;
  assign n_eff     = (ratio_use == '0) ? DIV_W'(1) : ratio_use;

  always_comb begin
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    fb_d    = fb_q;
    if (rise) begin
      ratio_d = ratio_use;
      if (cnt_q == n_eff - DIV_W'(1)) begin
        fb_d  = ~fb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dco_prev_q <= 1'b0;
      fb_q       <= 1'b0;
      cnt_q      <= '0;
      ratio_q    <= '0;
    end else begin
      dco_prev_q <= dco_i;
      fb_q       <= fb_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
    end
  end

  assign fb_clk_o = fb_q;

endmodule

// File: rtl/dco_nco.sv
// Digital DCO: phase accumulator driven by centre FCW plus scaled tuning, with feedback divider.
// Optional DITHER_EN adds a 16-bit Galois LFSR bit to the FCW LSB before accumulation.
module dco_nco
  import pll_pkg::*;
#(
  parameter logic [ACC_W-1:0] CENTER_FCW = 24'h100000,
  parameter int unsigned      GAIN_SHIFT = 0
) (
  input  logic     clk,
  input  logic     rst,
  dco_nco_if.slave bus
);

  fcw_sat_t         tune_s;
  logic [ACC_W-1:0] fcw_q;
  logic             sat_q;
  logic [ACC_W-1:0] phase_q, phase_d;
  logic [ACC_W-1:0] fcw_eff;
  logic             dco_q;

  always_comb tune_s = calc_fcw(bus.dac, CENTER_FCW, GAIN_SHIFT);

`ifdef DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end

  // The only value that can exceed Nyquist after the add is FCW_MAX itself.
  always_comb begin
    fcw_eff = fcw_q;
    if (fcw_q != FCW_MAX) fcw_eff = fcw_q + ACC_W'(lfsr_q[0]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 16'hACE1;
    else      lfsr_q <= lfsr_d;
  end
`else
  assign fcw_eff = fcw_q;
`endif

  assign phase_d = phase_q + fcw_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcw_q   <= CENTER_FCW;
      sat_q   <= 1'b0;
      phase_q <= '0;
      dco_q   <= 1'b0;
    end else begin
      fcw_q   <= tune_s.fcw;
      sat_q   <= tune_s.sat;
      phase_q <= phase_d;
      dco_q   <= phase_q[ACC_W-1];
    end
  end

  fb_divider u_fb_divider (
    .clk_i       (clk),
    .rst_ni      (rst),
    .dco_i       (dco_q),
    .div_ratio_i (bus.div_ratio),
    .fb_clk_o    (bus.fb_clk)
  );

  assign bus.dco_out = dco_q;
  assign bus.phase   = phase_q;
  assign bus.fcw     = fcw_q;
  assign bus.sat     = sat_q;

endmodule

// File: tb/tb_dco_nco.sv
// Directed bench for dco_nco: unity-gain instance plus a GAIN_SHIFT=4 instance for clamp cases.
module tb_dco_nco;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   n;

  always #5 clk = ~clk;

  dco_nco_if bus1 ();
  dco_nco_if bus2 ();

  dco_nco #(.CENTER_FCW(24'h100000), .GAIN_SHIFT(0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dco_nco #(.CENTER_FCW(24'h100000), .GAIN_SHIFT(4)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Returns clocks until bus1.fb_clk changes, bounded at 1000.
  task automatic wait_toggle(output int cnt);
    logic start;
    start = bus1.fb_clk;
    cnt   = 0;
    while (bus1.fb_clk === start && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    bus1.dac       = 20'h80000;
    bus1.div_ratio = 8'd4;
    bus2.dac       = 20'h00000;
    bus2.div_ratio = 8'd1;

    // Reset state
    step(3);
    check("rst_phase", 32'(bus1.phase), 32'h0);
    check("rst_fcw", 32'(bus1.fcw), 32'h100000);
    check("rst_dco", 32'(bus1.dco_out), 32'h0);
    check("rst_fb", 32'(bus1.fb_clk), 32'h0);
    check("rst_sat", 32'(bus1.sat), 32'h0);
    check("rst_fcw2", 32'(bus2.fcw), 32'h100000);
    @(negedge clk);
    rst = 1'b1;

    // First increment on the first edge after release
    step(1);
    check("ph_e1", 32'(bus1.phase), 32'h100000);
    check("ph2_e1", 32'(bus2.phase), 32'h100000);
    check("fcw2_lo_clamp", 32'(bus2.fcw), 32'h0);
    check("sat2_lo", 32'(bus2.sat), 32'h1);
    step(1);
    check("ph_e2", 32'(bus1.phase), 32'h200000);
    check("ph2_frozen_e2", 32'(bus2.phase), 32'h100000);
    step(6);
    check("ph_e8", 32'(bus1.phase), 32'h800000);
    check("dco_e8", 32'(bus1.dco_out), 32'h0);
    step(1);
    check("dco_e9", 32'(bus1.dco_out), 32'h1);
    step(7);
    check("dco_e16", 32'(bus1.dco_out), 32'h1);
    check("ph_e16", 32'(bus1.phase), 32'h0);
    step(1);
    check("dco_e17", 32'(bus1.dco_out), 32'h0);
    check("ph2_frozen_e17", 32'(bus2.phase), 32'h100000);
    check("dco2_frozen", 32'(bus2.dco_out), 32'h0);

    // Tuning latency and offsets at unity gain
    bus1.dac = 20'hFFFFF;
    #1;
    check("fcw_before_edge", 32'(bus1.fcw), 32'h100000);
    step(1);
    check("fcw_max_tune", 32'(bus1.fcw), 32'h17FFFF);
    check("sat_max_tune", 32'(bus1.sat), 32'h0);
    bus1.dac = 20'h00000;
    step(1);
    check("fcw_min_tune", 32'(bus1.fcw), 32'h080000);
    bus1.dac = 20'h80000;
    step(1);
    check("fcw_mid", 32'(bus1.fcw), 32'h100000);

    // Clamp with GAIN_SHIFT=4
    bus2.dac = 20'hFFFFF;
    step(1);
    check("fcw2_nyq", 32'(bus2.fcw), 32'h800000);
    check("sat2_nyq", 32'(bus2.sat), 32'h1);
    check("ph2_prev_zero_fcw", 32'(bus2.phase), 32'h100000);
    step(1);
    check("ph2_nyq1", 32'(bus2.phase), 32'h900000);
    step(1);
    check("ph2_nyq2", 32'(bus2.phase), 32'h100000);
    bus2.dac = 20'h00000;
    step(1);
    check("fcw2_zero", 32'(bus2.fcw), 32'h0);
    check("ph2_last_add", 32'(bus2.phase), 32'h900000);
    step(3);
    check("ph2_frozen", 32'(bus2.phase), 32'h900000);
    check("dco2_frozen_hi", 32'(bus2.dco_out), 32'h1);

    // Divider ratio 4 -> 64-clk half-periods
    wait_toggle(n);
    wait_toggle(n);
    wait_toggle(n);
    check("div4_half_a", 32'(n), 32'd64);
    wait_toggle(n);
    check("div4_half_b", 32'(n), 32'd64);

    // Ratio 0 treated as 1 -> 16-clk half-periods
    bus1.div_ratio = 8'd0;
    wait_toggle(n);
    wait_toggle(n);
    check("div0_half_a", 32'(n), 32'd16);
    wait_toggle(n);
    check("div0_half_b", 32'(n), 32'd16);

    // Mid-count change 4 -> 2 only applies after the next reload
    bus1.div_ratio = 8'd4;
    wait_toggle(n);
    wait_toggle(n);
    wait_toggle(n);
    check("div4_resync", 32'(n), 32'd64);
    repeat (20) @(negedge clk);
    bus1.div_ratio = 8'd2;
    wait_toggle(n);
    check("div_change_old", 32'(n + 20), 32'd64);
    wait_toggle(n);
    check("div_change_new_a", 32'(n), 32'd32);
    wait_toggle(n);
    check("div_change_new_b", 32'(n), 32'd32);

    // Asynchronous reset mid-cycle
    step(3);
    checks++;
    assert (bus1.phase !== 24'h0) else begin
      failures++;
      $error("FAIL pre_rst_phase_nz: observed=%0h expected=nonzero", bus1.phase);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_phase", 32'(bus1.phase), 32'h0);
    check("arst_fcw", 32'(bus1.fcw), 32'h100000);
    check("arst_dco", 32'(bus1.dco_out), 32'h0);
    check("arst_fb", 32'(bus1.fb_clk), 32'h0);
    check("arst_sat2", 32'(bus2.sat), 32'h0);
    check("arst_phase2", 32'(bus2.phase), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1);
    check("post_rst_ph", 32'(bus1.phase), 32'h100000);

`ifdef DITHER_EN
    begin
      logic [23:0] p0;
      logic [23:0] delta;
      step(16);
      p0 = bus1.phase;
      step(65536);
      delta = bus1.phase - p0;
      checks++;
      assert (delta >= 24'd32440 && delta <= 24'd33096) else begin
        failures++;
        $error("FAIL dither_mean: observed=%0d expected=32768+-328", delta);
      end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
